// File: rtl/or_gate_bist_seq_pkg.sv
// Shared state encoding and vector helpers for the OR-gate BIST sequencer.
package or_gate_bist_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int NUM_VECS = 4;
    localparam int GATE_W   = 2;

    function automatic logic gate_sel(input logic [GATE_W-1:0] gate, input int pos);
        return int'(gate) == pos;
    endfunction

    // The gate under test reads the OR of its two inputs; every idle gate sees 00 and reads 0.
    function automatic logic expected_y(input logic [GATE_W-1:0] gate, input int pos,
                                        input logic [1:0] vec);
        return gate_sel(gate, pos) & (vec[1] | vec[0]);
    endfunction

endpackage

// File: rtl/or_gate_bist_seq_if.sv
// Bundle between board test control, the sequencer and the OR gate bank.
interface or_gate_bist_seq_if #(
    parameter int GATES = 2
);
    logic             start;
    logic             abort;
    logic [0:GATES-1] a;
    logic [0:GATES-1] b;
    logic [0:GATES-1] y;
    logic             busy;
    logic             done;
    logic             pass;
    logic [0:GATES-1] fail_mask;

    modport master (
        input  start, abort, y,
        output a, b, busy, done, pass, fail_mask
    );

    modport slave (
        output start, abort, y,
        input  a, b, busy, done, pass, fail_mask
    );
endinterface

// File: rtl/or_bist_vec_counter.sv
// Hold / vector / gate counters that pace the BIST walk and flag the end of each loop.
module or_bist_vec_counter
    import or_gate_bist_seq_pkg::*;
#(
    parameter int GATES  = 2,
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              clear,
    input  logic              advance,
    output logic [GATE_W-1:0] gate,
    output logic [GATE_W-1:0] gate_nxt,
    output logic [1:0]        vec,
    output logic [1:0]        vec_nxt,
    output logic              last_hold,
    output logic              last_vec,
    output logic              last_gate
);
    localparam int HOLD_W = $clog2(SETTLE + 1);

    logic [HOLD_W-1:0] hold;
    logic [HOLD_W-1:0] hold_nxt;

    assign last_hold = (hold == HOLD_W'(SETTLE - 1));
    assign last_vec  = (vec == 2'(NUM_VECS - 1));
    assign last_gate = (gate == GATE_W'(GATES - 1));

    // Next values are exported so the top can register A/B in step with the counters.
    always_comb begin
        hold_nxt = hold;
        vec_nxt  = vec;
        gate_nxt = gate;
        if (clear) begin
            hold_nxt = '0;
            vec_nxt  = '0;
            gate_nxt = '0;
        end else if (advance) begin
            if (last_hold) begin
                hold_nxt = '0;
                vec_nxt  = vec + 2'd1;
                if (last_vec) begin
                    gate_nxt = last_gate ? '0 : gate + 1'b1;
                end
            end else begin
                hold_nxt = hold + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            hold <= '0;
            vec  <= '0;
            gate <= '0;
        end else begin
            hold <= hold_nxt;
            vec  <= vec_nxt;
            gate <= gate_nxt;
        end
    end

endmodule

// File: rtl/or_gate_bist_seq.sv
// BIST sequencer: walks every gate through 00..11, checks Y after the settle time, reports pass/fail.
module or_gate_bist_seq
    import or_gate_bist_seq_pkg::*;
#(
    parameter int GATES  = 2,
    parameter int SETTLE = 2
) (
    input logic                clk,
    input logic                clr_n,
    or_gate_bist_seq_if.master bus
);
    state_t            state;
    state_t            state_nxt;
    logic [0:GATES-1]  a_q, b_q, a_d, b_d;
    logic [0:GATES-1]  fail_q, fail_d;
    logic [0:GATES-1]  exp_y;
    logic [GATE_W-1:0] gate, gate_nxt;
    logic [1:0]        vec, vec_nxt;
    logic              last_hold, last_vec, last_gate;
    logic              final_check;

    assign final_check = last_hold & last_vec & last_gate;

    or_bist_vec_counter #(
        .GATES  (GATES),
        .SETTLE (SETTLE)
    ) u_counter (
        .clk       (clk),
        .clr_n     (clr_n),
        .clear     (state_nxt != ST_RUN),
        .advance   (state == ST_RUN),
        .gate      (gate),
        .gate_nxt  (gate_nxt),
        .vec       (vec),
        .vec_nxt   (vec_nxt),
        .last_hold (last_hold),
        .last_vec  (last_vec),
        .last_gate (last_gate)
    );

    always_comb begin
        exp_y = '0;
        for (int j = 0; j < GATES; j++) begin
            exp_y[j] = expected_y(gate, j, vec);
        end
    end

    // ABORT outranks the final check, so an aborted run never reaches DONE.
    always_comb begin
        state_nxt = state;
        fail_d    = fail_q;
        unique case (state)
            ST_IDLE: begin
                if (bus.start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (bus.abort) begin
                    state_nxt = ST_IDLE;
                    fail_d    = '0;
                end else begin
                    if (last_hold) fail_d = fail_q | (bus.y ^ exp_y);
                    if (final_check) state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    state_nxt = ST_RUN;
                    fail_d    = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                fail_d    = '0;
            end
        endcase
    end

    always_comb begin
        a_d = '0;
        b_d = '0;
        if (state_nxt == ST_RUN) begin
            for (int j = 0; j < GATES; j++) begin
                a_d[j] = gate_sel(gate_nxt, j) & vec_nxt[1];
                b_d[j] = gate_sel(gate_nxt, j) & vec_nxt[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state  <= ST_IDLE;
            a_q    <= '0;
            b_q    <= '0;
            fail_q <= '0;
        end else begin
            state  <= state_nxt;
            a_q    <= a_d;
            b_q    <= b_d;
            fail_q <= fail_d;
        end
    end

    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.busy      = (state == ST_RUN);
    assign bus.done      = (state == ST_DONE);
    assign bus.pass      = (state == ST_DONE) && (fail_q == '0);
    assign bus.fail_mask = fail_q;

endmodule

// File: tb/tb_or_gate_bist_seq.sv
// Self-checking bench for or_gate_bist_seq: faulty gate-bank models, table runs, corner sequences, random runs.
module tb_or_gate_bist_seq;
    localparam int GATES      = 2;
    localparam int SETTLE     = 2;
    localparam int RUN_CYCLES = 4 * GATES * SETTLE;
    localparam int K_GOOD = 0, K_S0 = 1, K_S1 = 2, K_AND = 3, K_XOR = 4, K_NOR = 5;

    typedef struct {
        int               k0;
        int               k1;
        logic [0:GATES-1] fm;
        logic             pass;
    } vec_t;

    logic clk = 1'b0;
    logic clr_n;
    int   gate_kind [0:GATES-1];
    int   checks = 0;
    int   errors = 0;
    int   cycles;
    vec_t tbl [0:5];
    logic [0:GATES-1] ref_fm;

    or_gate_bist_seq_if #(.GATES(GATES)) bus ();

    or_gate_bist_seq #(.GATES(GATES), .SETTLE(SETTLE)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic model_gate(input int kind, input logic a, input logic b);
        case (kind)
            K_S0:    return 1'b0;
            K_S1:    return 1'b1;
            K_AND:   return a & b;
            K_XOR:   return a ^ b;
            K_NOR:   return ~(a | b);
            default: return a | b;
        endcase
    endfunction

    always_comb begin
        bus.y = '0;
        for (int j = 0; j < GATES; j++) begin
            bus.y[j] = model_gate(gate_kind[j], bus.a[j], bus.b[j]);
        end
    end

    // Walk every (gate, vector) pair and mark any gate whose modelled output disagrees with a good OR bank.
    function automatic logic [0:GATES-1] ref_fail_mask();
        logic [0:GATES-1] m;
        logic ain, bin;
        m = '0;
        for (int g = 0; g < GATES; g++) begin
            for (int v = 0; v < 4; v++) begin
                for (int j = 0; j < GATES; j++) begin
                    ain = (j == g) && ((v & 2) != 0);
                    bin = (j == g) && ((v & 1) != 0);
                    if (model_gate(gate_kind[j], ain, bin) != (ain | bin)) m[j] = 1'b1;
                end
            end
        end
        return m;
    endfunction

    function automatic logic [0:GATES-1] exp_drive(input int t, input bit is_a);
        logic [0:GATES-1] r;
        int n, g, v;
        n = t / SETTLE;
        g = n / 4;
        v = n % 4;
        r = '0;
        r[g] = is_a ? ((v & 2) != 0) : ((v & 1) != 0);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic ab);
        bus.start = s;
        bus.abort = ab;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    task automatic setKinds(input int k0, input int k1);
        gate_kind[0] = k0;
        gate_kind[1] = k1;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_busy"}, bus.busy, 0);
        checkOutput({tag, "_done"}, bus.done, 0);
        checkOutput({tag, "_pass"}, bus.pass, 0);
        checkOutput({tag, "_a"}, bus.a, 0);
        checkOutput({tag, "_b"}, bus.b, 0);
        checkOutput({tag, "_fail_mask"}, bus.fail_mask, 0);
    endtask

    task automatic waitDone(output int n);
        n = 0;
        while (!bus.done && n < 200) begin
            step();
            n++;
        end
    endtask

    task automatic runToDone(output int n);
        applyStimulus(1'b1, 1'b0);
        waitDone(n);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tbl[0] = '{K_GOOD, K_GOOD, 2'b00, 1'b1};
        tbl[1] = '{K_GOOD, K_S0,   2'b01, 1'b0};
        tbl[2] = '{K_AND,  K_GOOD, 2'b10, 1'b0};
        tbl[3] = '{K_S1,   K_GOOD, 2'b10, 1'b0};
        tbl[4] = '{K_XOR,  K_XOR,  2'b11, 1'b0};
        tbl[5] = '{K_GOOD, K_NOR,  2'b01, 1'b0};

        bus.start = 1'b0;
        bus.abort = 1'b0;
        clr_n     = 1'b0;
        setKinds(K_GOOD, K_GOOD);
        step();
        step();
        checkIdle("reset");
        clr_n = 1'b1;
        step();

        // Clean run: A/B trace, BUSY window and DONE timing.
        applyStimulus(1'b1, 1'b0);
        for (int t = 0; t < RUN_CYCLES; t++) begin
            checkOutput($sformatf("trace_busy_t%0d", t), bus.busy, 1);
            checkOutput($sformatf("trace_a_t%0d", t), bus.a, exp_drive(t, 1'b1));
            checkOutput($sformatf("trace_b_t%0d", t), bus.b, exp_drive(t, 1'b0));
            step();
        end
        checkOutput("trace_done", bus.done, 1);
        checkOutput("trace_pass", bus.pass, 1);
        checkOutput("trace_busy_end", bus.busy, 0);
        checkOutput("trace_a_end", bus.a, 0);
        checkOutput("trace_fail_mask", bus.fail_mask, 0);

        for (int i = 0; i < 6; i++) begin
            setKinds(tbl[i].k0, tbl[i].k1);
            runToDone(cycles);
            checkOutput($sformatf("table%0d_run_length", i), cycles, RUN_CYCLES);
            checkOutput($sformatf("table%0d_done", i), bus.done, 1);
            checkOutput($sformatf("table%0d_pass", i), bus.pass, tbl[i].pass);
            checkOutput($sformatf("table%0d_fail_mask", i), bus.fail_mask, tbl[i].fm);
        end

        // Restart from DONE clears an earlier failure.
        setKinds(K_GOOD, K_S0);
        runToDone(cycles);
        checkOutput("restart_prior_mask", bus.fail_mask, 2'b01);
        setKinds(K_GOOD, K_GOOD);
        applyStimulus(1'b1, 1'b0);
        checkOutput("restart_mask_cleared", bus.fail_mask, 0);
        checkOutput("restart_done_cleared", bus.done, 0);
        checkOutput("restart_pass_cleared", bus.pass, 0);
        checkOutput("restart_busy", bus.busy, 1);
        waitDone(cycles);
        checkOutput("restart_run_length", cycles, RUN_CYCLES);
        checkOutput("restart_pass", bus.pass, 1);

        applyStimulus(1'b0, 1'b1);
        checkOutput("abort_in_done_done", bus.done, 1);
        checkOutput("abort_in_done_pass", bus.pass, 1);

        // Abort mid-run after a mismatch was already recorded.
        setKinds(K_AND, K_GOOD);
        applyStimulus(1'b1, 1'b0);
        for (int t = 0; t < 6; t++) step();
        checkOutput("abort_mid_pre_mask", bus.fail_mask, 2'b10);
        applyStimulus(1'b0, 1'b1);
        checkIdle("abort_mid");
        step();
        step();
        checkOutput("abort_mid_stays_idle", bus.busy, 0);

        setKinds(K_GOOD, K_GOOD);
        applyStimulus(1'b1, 1'b1);
        checkOutput("start_wins_busy", bus.busy, 1);
        waitDone(cycles);
        checkOutput("start_wins_run_length", cycles, RUN_CYCLES);
        checkOutput("start_wins_pass", bus.pass, 1);

        // ABORT landing on the final check edge.
        applyStimulus(1'b1, 1'b0);
        for (int t = 0; t < RUN_CYCLES - 1; t++) step();
        checkOutput("abort_final_busy_before", bus.busy, 1);
        applyStimulus(1'b0, 1'b1);
        checkIdle("abort_final");
        step();
        step();
        checkOutput("abort_final_no_done", bus.done, 0);

        // Synchronous reset mid-run, then a clean run.
        applyStimulus(1'b1, 1'b0);
        for (int t = 0; t < 4; t++) step();
        clr_n = 1'b0;
        step();
        checkIdle("reset_mid");
        clr_n = 1'b1;
        runToDone(cycles);
        checkOutput("reset_mid_run_length", cycles, RUN_CYCLES);
        checkOutput("reset_mid_pass", bus.pass, 1);

        // START held high through the run must not restart it.
        applyStimulus(1'b0, 1'b1);
        bus.start = 1'b1;
        step();
        for (int t = 0; t < RUN_CYCLES; t++) begin
            checkOutput($sformatf("held_start_busy_t%0d", t), bus.busy, 1);
            checkOutput($sformatf("held_start_a_t%0d", t), bus.a, exp_drive(t, 1'b1));
            step();
        end
        bus.start = 1'b0;
        checkOutput("held_start_done", bus.done, 1);
        checkOutput("held_start_pass", bus.pass, 1);

        for (int i = 0; i < 12; i++) begin
            setKinds(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
            ref_fm = ref_fail_mask();
            runToDone(cycles);
            checkOutput($sformatf("rand%0d_run_length", i), cycles, RUN_CYCLES);
            checkOutput($sformatf("rand%0d_fail_mask", i), bus.fail_mask, ref_fm);
            checkOutput($sformatf("rand%0d_pass", i), bus.pass, ref_fm == '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
